// File: rtl/cgra_pkg.sv
// Shared CGRA dimensions used across the array front end and controller.
package cgra_pkg;

  localparam int unsigned N_COL               = 4;
  localparam int unsigned N_COL_LOG2          = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int unsigned KER_CONF_N_REG      = 16;
  localparam int unsigned KER_CONF_N_REG_LOG2 = $clog2(KER_CONF_N_REG);

endpackage

// File: rtl/cgra_prio_enc.sv
// Lowest-set-bit encoder: reports whether any request is set and the index of the lowest one.
module cgra_prio_enc #(
  parameter int unsigned W  = 4,
  parameter int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Scan from the top so the last hit, the lowest set bit, wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cgra_synchronizer.sv
// Kernel-launch front end: holds one pending launch, hands it to the controller, tracks
// per-kernel column occupancy and reports each kernel's completion to the host.
module cgra_synchronizer #(
  parameter int unsigned N_COL = cgra_pkg::N_COL,
  parameter int unsigned KID_W = cgra_pkg::KER_CONF_N_REG_LOG2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [N_COL-1:0] start_col_mask_i,
  input  logic [KID_W-1:0] start_ker_id_i,
  output logic             start_ready_o,
  output logic             start_err_o,
  output logic [N_COL-1:0] acc_req_o,
  output logic [KID_W-1:0] ker_id_req_o,
  input  logic             acc_ack_i,
  input  logic [N_COL-1:0] col_start_i,
  input  logic [N_COL-1:0] acc_end_i,
  output logic [N_COL-1:0] col_busy_o,
  output logic [N_COL-1:0] col_run_o,
  output logic             done_valid_o,
  output logic [KID_W-1:0] done_ker_id_o,
  output logic [N_COL-1:0] done_col_mask_o,
  input  logic             done_ready_i
);

  localparam int unsigned IW = (N_COL > 1) ? $clog2(N_COL) : 1;

  logic             pend_v_reg;
  logic [N_COL-1:0] pend_mask_reg;
  logic [KID_W-1:0] pend_kid_reg;
  logic             start_err_reg;
  logic [N_COL-1:0] col_busy_reg, col_busy_next;
  logic [N_COL-1:0] col_run_reg, col_run_next;
  logic [N_COL-1:0] grp_v_reg, grp_v_next;
  logic [N_COL-1:0] done_pend_reg, done_pend_next;
  logic [N_COL-1:0] grp_rem_reg  [N_COL];
  logic [N_COL-1:0] grp_rem_next [N_COL];
  logic [N_COL-1:0] grp_mask_reg [N_COL];
  logic [KID_W-1:0] grp_kid_reg  [N_COL];
  logic             hold_v_reg;
  logic [IW-1:0]    hold_idx_reg;

  logic             slot_valid;
  logic [IW-1:0]    slot;
  logic             done_any;
  logic [IW-1:0]    done_low;
  logic [IW-1:0]    done_sel;
  logic             issue;
  logic             ack;
  logic             load;
  logic             pop;
  logic [N_COL-1:0] end_eff;
  logic [N_COL-1:0] slot_load;
  logic [N_COL-1:0] slot_complete;
  logic [N_COL-1:0] slot_pop;

  cgra_prio_enc #(.W(N_COL), .IW(IW)) u_slot_enc (
    .req   (pend_mask_reg),
    .valid (slot_valid),
    .index (slot)
  );

  cgra_prio_enc #(.W(N_COL), .IW(IW)) u_done_enc (
    .req   (done_pend_reg),
    .valid (done_any),
    .index (done_low)
  );

  assign issue   = pend_v_reg & slot_valid & ((col_busy_reg & pend_mask_reg) == '0)
                 & ~done_pend_reg[slot] & ~grp_v_reg[slot];
  assign ack     = acc_ack_i & issue;
  assign load    = start_i & ~pend_v_reg & (start_col_mask_i != '0);
  assign end_eff = acc_end_i & col_busy_reg;
  // Once an event is shown it stays selected until taken, even if a lower slot completes.
  assign done_sel = hold_v_reg ? hold_idx_reg : done_low;
  assign pop      = done_any & done_ready_i;

  assign start_ready_o   = ~pend_v_reg;
  assign start_err_o     = start_err_reg;
  assign acc_req_o       = issue ? pend_mask_reg : '0;
  assign ker_id_req_o    = pend_kid_reg;
  assign col_busy_o      = col_busy_reg;
  assign col_run_o       = col_run_reg;
  assign done_valid_o    = done_any;
  assign done_ker_id_o   = done_any ? grp_kid_reg[done_sel] : '0;
  assign done_col_mask_o = done_any ? grp_mask_reg[done_sel] : '0;

  assign col_busy_next = (col_busy_reg & ~end_eff) | (ack ? pend_mask_reg : '0);
  assign col_run_next  = (col_run_reg | (col_start_i & col_busy_reg)) & ~end_eff;

  for (genvar gi = 0; gi < N_COL; gi++) begin : g_slot
    assign slot_load[gi]     = ack & (slot == IW'(gi));
    assign grp_rem_next[gi]  = slot_load[gi] ? pend_mask_reg : (grp_rem_reg[gi] & ~end_eff);
    assign slot_complete[gi] = grp_v_reg[gi] & ~slot_load[gi] & (grp_rem_next[gi] == '0);
    assign slot_pop[gi]      = pop & (done_sel == IW'(gi));
    assign grp_v_next[gi]    = slot_load[gi] | (grp_v_reg[gi] & ~slot_complete[gi]);
    assign done_pend_next[gi] = slot_complete[gi] | (done_pend_reg[gi] & ~slot_pop[gi]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_v_reg    <= 1'b0;
      pend_mask_reg <= '0;
      pend_kid_reg  <= '0;
      start_err_reg <= 1'b0;
      col_busy_reg  <= '0;
      col_run_reg   <= '0;
      grp_v_reg     <= '0;
      done_pend_reg <= '0;
      hold_v_reg    <= 1'b0;
      hold_idx_reg  <= '0;
      for (int i = 0; i < N_COL; i++) begin
        grp_rem_reg[i]  <= '0;
        grp_mask_reg[i] <= '0;
        grp_kid_reg[i]  <= '0;
      end
    end else begin
      start_err_reg <= start_i & ~pend_v_reg & (start_col_mask_i == '0);
      if (load) begin
        pend_v_reg    <= 1'b1;
        pend_mask_reg <= start_col_mask_i;
        pend_kid_reg  <= start_ker_id_i;
      end else if (ack) begin
        pend_v_reg <= 1'b0;
      end
      col_busy_reg  <= col_busy_next;
      col_run_reg   <= col_run_next;
      grp_v_reg     <= grp_v_next;
      done_pend_reg <= done_pend_next;
      hold_v_reg    <= done_any & ~done_ready_i;
      hold_idx_reg  <= done_sel;
      for (int i = 0; i < N_COL; i++) begin
        grp_rem_reg[i] <= grp_rem_next[i];
        if (slot_load[i]) begin
          grp_mask_reg[i] <= pend_mask_reg;
          grp_kid_reg[i]  <= pend_kid_reg;
        end
      end
    end
  end

  a_ack_while_issuing: assert property (@(posedge clk_i) disable iff (!rst_ni)
    acc_ack_i |-> issue);
  a_end_on_busy_col: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (acc_end_i & ~col_busy_reg) == '0);

endmodule

// File: tb/tb_cgra_synchronizer.sv
// Directed bench for the kernel-launch front end; completion events are checked against a queue.
module tb_cgra_synchronizer;

  localparam int unsigned NC = cgra_pkg::N_COL;
  localparam int unsigned KW = cgra_pkg::KER_CONF_N_REG_LOG2;

  typedef struct packed {
    logic [KW-1:0] kid;
    logic [NC-1:0] mask;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NC-1:0] start_mask = '0;
  logic [KW-1:0] start_kid = '0;
  logic          start_ready;
  logic          start_err;
  logic [NC-1:0] acc_req;
  logic [KW-1:0] ker_id_req;
  logic          acc_ack = 1'b0;
  logic [NC-1:0] col_start = '0;
  logic [NC-1:0] acc_end = '0;
  logic [NC-1:0] col_busy;
  logic [NC-1:0] col_run;
  logic          done_valid;
  logic [KW-1:0] done_kid;
  logic [NC-1:0] done_mask;
  logic          done_ready = 1'b1;

  ev_t sb[$];
  int  compared = 0;
  int  mismatched = 0;

  always #5 clk = ~clk;

  cgra_synchronizer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .start_col_mask_i (start_mask),
    .start_ker_id_i   (start_kid),
    .start_ready_o    (start_ready),
    .start_err_o      (start_err),
    .acc_req_o        (acc_req),
    .ker_id_req_o     (ker_id_req),
    .acc_ack_i        (acc_ack),
    .col_start_i      (col_start),
    .acc_end_i        (acc_end),
    .col_busy_o       (col_busy),
    .col_run_o        (col_run),
    .done_valid_o     (done_valid),
    .done_ker_id_o    (done_kid),
    .done_col_mask_o  (done_mask),
    .done_ready_i     (done_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic [NC-1:0] m, input logic [KW-1:0] k);
    start = 1'b1; start_mask = m; start_kid = k;
    tick();
    start = 1'b0; start_mask = '0; start_kid = '0;
    $display("launch mask=%b kid=%0d", m, k);
  endtask

  task automatic ack_push(input logic [NC-1:0] m, input logic [KW-1:0] k);
    ev_t e;
    e.kid = k; e.mask = m;
    sb.push_back(e);
    acc_ack = 1'b1;
    tick();
    acc_ack = 1'b0;
    $display("ack mask=%b kid=%0d", m, k);
  endtask

  task automatic pop_expect(input string tag);
    ev_t e;
    chk({tag, "_valid"}, 32'(done_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_kid"}, 32'(done_kid), 32'(e.kid));
      chk({tag, "_mask"}, 32'(done_mask), 32'(e.mask));
    end
    $display("done %s kid=%0d mask=%b", tag, done_kid, done_mask);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_acc_req", 32'(acc_req), 32'd0);
    chk("rst_ker_id_req", 32'(ker_id_req), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_col_busy", 32'(col_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single launch, ack at t+3, end at t+20
    launch(4'b0001, 4'd3);
    chk("t1_req1", 32'(acc_req), 32'b0001);
    chk("t1_kid_req", 32'(ker_id_req), 32'd3);
    chk("t1_ready_low", 32'(start_ready), 32'd0);
    tick();
    chk("t1_req2", 32'(acc_req), 32'b0001);
    tick();
    chk("t1_req3", 32'(acc_req), 32'b0001);
    ack_push(4'b0001, 4'd3);
    chk("t1_req_drop", 32'(acc_req), 32'd0);
    chk("t1_busy", 32'(col_busy), 32'b0001);
    chk("t1_ready_back", 32'(start_ready), 32'd1);
    col_start = 4'b0001;
    tick();
    col_start = '0;
    chk("t1_run", 32'(col_run), 32'b0001);
    repeat (14) tick();
    chk("t1_no_done_early", 32'(done_valid), 32'd0);
    tick();
    acc_end = 4'b0001;
    tick();
    acc_end = '0;
    pop_expect("t1");
    chk("t1_busy_clear", 32'(col_busy), 32'd0);
    chk("t1_run_clear", 32'(col_run), 32'd0);
    tick();
    chk("t1_done_gone", 32'(done_valid), 32'd0);

    // Two-column kernel, staggered ends
    launch(4'b0011, 4'd5);
    chk("t2_req", 32'(acc_req), 32'b0011);
    ack_push(4'b0011, 4'd5);
    col_start = 4'b0011;
    tick();
    col_start = '0;
    acc_end = 4'b0010;
    tick();
    acc_end = '0;
    chk("t2_partial_no_done", 32'(done_valid), 32'd0);
    chk("t2_busy_partial", 32'(col_busy), 32'b0001);
    chk("t2_run_partial", 32'(col_run), 32'b0001);
    tick();
    tick();
    tick();
    chk("t2_still_no_done", 32'(done_valid), 32'd0);
    acc_end = 4'b0001;
    tick();
    acc_end = '0;
    pop_expect("t2");
    tick();
    chk("t2_done_gone", 32'(done_valid), 32'd0);

    // Two kernels ending together, drained on consecutive cycles
    launch(4'b0001, 4'd1);
    ack_push(4'b0001, 4'd1);
    launch(4'b0110, 4'd2);
    chk("t3_req_b", 32'(acc_req), 32'b0110);
    ack_push(4'b0110, 4'd2);
    chk("t3_busy", 32'(col_busy), 32'b0111);
    acc_end = 4'b0111;
    tick();
    acc_end = '0;
    pop_expect("t3_first");
    tick();
    pop_expect("t3_second");
    tick();
    chk("t3_drained", 32'(done_valid), 32'd0);

    // Launch blocked by a busy column
    launch(4'b0011, 4'd7);
    ack_push(4'b0011, 4'd7);
    launch(4'b0010, 4'd9);
    for (int i = 0; i < 3; i++) begin
      chk("t4_blocked_req", 32'(acc_req), 32'd0);
      chk("t4_ready_low", 32'(start_ready), 32'd0);
      tick();
    end
    acc_end = 4'b0011;
    tick();
    acc_end = '0;
    pop_expect("t4_c");
    chk("t4_req_after_free", 32'(acc_req), 32'b0010);
    chk("t4_kid_req", 32'(ker_id_req), 32'd9);
    ack_push(4'b0010, 4'd9);
    acc_end = 4'b0010;
    tick();
    acc_end = '0;
    pop_expect("t4_d");
    tick();

    // Unconsumed event blocks a launch that maps to the same slot
    done_ready = 1'b0;
    launch(4'b0001, 4'd4);
    ack_push(4'b0001, 4'd4);
    acc_end = 4'b0001;
    tick();
    acc_end = '0;
    chk("t5_valid_held", 32'(done_valid), 32'd1);
    launch(4'b0001, 4'd6);
    for (int i = 0; i < 3; i++) begin
      chk("t5_blocked_req", 32'(acc_req), 32'd0);
      chk("t5_stable_kid", 32'(done_kid), 32'd4);
      chk("t5_stable_mask", 32'(done_mask), 32'b0001);
      tick();
    end
    done_ready = 1'b1;
    pop_expect("t5_e");
    tick();
    chk("t5_req_after_pop", 32'(acc_req), 32'b0001);
    chk("t5_valid_cleared", 32'(done_valid), 32'd0);
    ack_push(4'b0001, 4'd6);
    acc_end = 4'b0001;
    tick();
    acc_end = '0;
    pop_expect("t5_f");
    tick();

    // Zero-mask launch is rejected
    start = 1'b1; start_mask = '0; start_kid = 4'd2;
    tick();
    start = 1'b0; start_kid = '0;
    $display("launch mask=0000 kid=2 (rejected)");
    chk("t6_err_pulse", 32'(start_err), 32'd1);
    chk("t6_ready_kept", 32'(start_ready), 32'd1);
    chk("t6_no_req", 32'(acc_req), 32'd0);
    tick();
    chk("t6_err_gone", 32'(start_err), 32'd0);

    // Reset during execution discards the kernel
    launch(4'b1000, 4'd5);
    chk("t7_req", 32'(acc_req), 32'b1000);
    acc_ack = 1'b1;
    tick();
    acc_ack = 1'b0;
    col_start = 4'b1000;
    tick();
    col_start = '0;
    chk("t7_run", 32'(col_run), 32'b1000);
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-execution");
    chk("t7_rst_busy", 32'(col_busy), 32'd0);
    chk("t7_rst_run", 32'(col_run), 32'd0);
    chk("t7_rst_req", 32'(acc_req), 32'd0);
    chk("t7_rst_kid_req", 32'(ker_id_req), 32'd0);
    chk("t7_rst_ready", 32'(start_ready), 32'd1);
    chk("t7_rst_done", 32'(done_valid), 32'd0);
    chk("t7_rst_done_kid", 32'(done_kid), 32'd0);
    chk("t7_rst_done_mask", 32'(done_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t7_post_busy", 32'(col_busy), 32'd0);
    chk("t7_post_done", 32'(done_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
